ram_port_arbiter: RTL and testbench

//   Shares the single data-RAM port between the CPU MEM stage and an external

---
 rtl/ram_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single data-RAM port between the CPU MEM stage
// and an external loader/debug port (EXT). One beat per cycle, 1-cycle read
// return routed back to the beat's owner, bounded EXT starvation.
// Optional build macro RAM_ARB_RR_EN: when both ports request (and no lock or
// starvation override applies), alternate winners instead of CPU priority.
module ram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  input  logic              ext_lock,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ram_read_enable,
  output logic              ram_write_enable,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  // Owner of the read beat whose data appears on ram_rdata this cycle.
  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_CPU  = 2'd1,
    RD_EXT  = 2'd2
  } rd_owner_t;

  rd_owner_t         rd_owner_reg, rd_owner_next;
  logic              locked_reg, locked_next;
  logic [CNT_W-1:0]  starve_cnt_reg, starve_cnt_next;
  logic [DATA_W-1:0] cpu_rdata_reg, ext_rdata_reg;
  logic              cpu_win, ext_win;
  logic              starved;

`ifdef RAM_ARB_RR_EN
  // 0 = CPU won the most recent grant, 1 = EXT did.
  logic              last_winner_reg;
`endif

  assign starved = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  // Winner selection: lock, then starvation override, then tie-break, then single requester.
  // The reset cycle grants nothing so the RAM sees no beat while state is cleared.
  always_comb begin
    cpu_win = 1'b0;
    ext_win = 1'b0;
    if (!reset) begin
      if (locked_reg && ext_req) begin
        ext_win = 1'b1;
      end else if (starved && ext_req) begin
        ext_win = 1'b1;
      end else if (cpu_req && ext_req) begin
`ifdef RAM_ARB_RR_EN
        if (last_winner_reg) cpu_win = 1'b1;
        else                 ext_win = 1'b1;
`else
        cpu_win = 1'b1;
`endif
      end else if (cpu_req) begin
        cpu_win = 1'b1;
      end else if (ext_req) begin
        ext_win = 1'b1;
      end
    end
  end

  // RAM port drive and requester handshakes; idle cycles drive zeros.
  always_comb begin
    ram_addr         = '0;
    ram_wdata        = '0;
    ram_write_enable = 1'b0;
    ram_read_enable  = 1'b0;
    if (cpu_win) begin
      ram_addr         = cpu_addr;
      ram_wdata        = cpu_wdata;
      ram_write_enable = cpu_we;
      ram_read_enable  = ~cpu_we;
    end else if (ext_win) begin
      ram_addr         = ext_addr;
      ram_wdata        = ext_wdata;
      ram_write_enable = ext_we;
      ram_read_enable  = ~ext_we;
    end
    cpu_gnt   = cpu_win;
    ext_gnt   = ext_win;
    cpu_stall = cpu_req & ~cpu_win;
  end

  // Next-state: read-return owner, burst lock and EXT starvation counter.
  always_comb begin
    rd_owner_next   = RD_NONE;
    locked_next     = ext_win & ext_lock;
    starve_cnt_next = starve_cnt_reg;
    if (cpu_win && !cpu_we) begin
      rd_owner_next = RD_CPU;
    end else if (ext_win && !ext_we) begin
      rd_owner_next = RD_EXT;
    end
    if (!ext_req || ext_win) begin
      starve_cnt_next = '0;
    end else if (!starved) begin
      starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  // Read return outputs: valid while the owner's beat is on ram_rdata,
  // otherwise the last returned word is held. Forced to zero during reset.
  always_comb begin
    cpu_rvalid = !reset && (rd_owner_reg == RD_CPU);
    ext_rvalid = !reset && (rd_owner_reg == RD_EXT);
    cpu_rdata  = reset ? '0 : (cpu_rvalid ? ram_rdata : cpu_rdata_reg);
    ext_rdata  = reset ? '0 : (ext_rvalid ? ram_rdata : ext_rdata_reg);
  end

  // State registers; a reset drops any pending read return.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_reg   <= RD_NONE;
      locked_reg     <= 1'b0;
      starve_cnt_reg <= '0;
      cpu_rdata_reg  <= '0;
      ext_rdata_reg  <= '0;
    end else begin
      rd_owner_reg   <= rd_owner_next;
      locked_reg     <= locked_next;
      starve_cnt_reg <= starve_cnt_next;
      if (cpu_rvalid) cpu_rdata_reg <= ram_rdata;
      if (ext_rvalid) ext_rdata_reg <= ram_rdata;
    end
  end

`ifdef RAM_ARB_RR_EN
  // Remember who won the last grant so a tie goes to the other port next time.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_winner_reg <= 1'b0;
    end else if (cpu_win) begin
      last_winner_reg <= 1'b0;
    end else if (ext_win) begin
      last_winner_reg <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: drives beats, keeps a shadow copy
// of RAM contents, queues expected read data per port and checks returns.
module tb_ram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, ext_req, ext_we, ext_lock;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] cpu_rdata, ext_rdata;
  logic        ram_read_enable, ram_write_enable;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mem    [0:255];
  logic [31:0] shadow [0:255];
  logic [31:0] cpu_q[$];
  logic [31:0] ext_q[$];
  logic [31:0] last_cpu_data = 32'h0;
  logic [31:0] last_ext_data = 32'h0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_lock(ext_lock), .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .ram_read_enable(ram_read_enable), .ram_write_enable(ram_write_enable),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous single-port RAM, data valid the cycle after a read enable.
  always @(posedge clk) begin
    if (ram_write_enable) mem[ram_addr[9:2]] <= ram_wdata;
    if (ram_read_enable)  ram_rdata <= mem[ram_addr[9:2]];
  end

  task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                       input logic er, input logic ew, input logic el,
                       input logic [31:0] ea, input logic [31:0] ed);
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    ext_req = er; ext_we = ew; ext_lock = el; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, ram_read_enable, ram_write_enable, cpu_rvalid, ext_rvalid} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got gnt=%b/%b en=%b/%b rvalid=%b/%b required all 0",
               cpu_gnt, ext_gnt, ram_read_enable, ram_write_enable, cpu_rvalid, ext_rvalid);
    end
    checks++;
    if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0 || ram_addr !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got cpu_rdata=%h ext_rdata=%h ram_addr=%h required 0",
               cpu_rdata, ext_rdata, ram_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin
      failures++;
      $display("FAIL post_reset got rvalid=%b/%b cpu_rdata=%h required 0/0/0", cpu_rvalid, ext_rvalid, cpu_rdata);
    end
    $display("test_reset done");
  endtask

  task automatic test_store_load();
    logic [31:0] exp;
    @(posedge clk); #1;
    drive(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_write_enable !== 1'b1 ||
        ram_read_enable !== 1'b0 || ram_addr !== 32'h10 || ram_wdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL sw_beat got gnt=%b stall=%b we=%b re=%b addr=%h wdata=%h required 1 0 1 0 00000010 deadbeef",
               cpu_gnt, cpu_stall, ram_write_enable, ram_read_enable, ram_addr, ram_wdata);
    end
    shadow[4] = 32'hDEADBEEF;
    $display("SW  addr=00000010 data=deadbeef gnt=%b", cpu_gnt);
    @(posedge clk); #1;
    drive(1, 0, 32'h10, 32'h0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0 || ram_read_enable !== 1'b1 || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL lw_beat got gnt=%b stall=%b re=%b rvalid=%b required 1 0 1 0",
               cpu_gnt, cpu_stall, ram_read_enable, cpu_rvalid);
    end
    cpu_q.push_back(shadow[4]);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp = cpu_q.pop_front();
    checks++;
    if (cpu_rvalid !== 1'b1 || cpu_rdata !== exp || ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL lw_return got rvalid=%b rdata=%h ext_rvalid=%b required 1 %h 0",
               cpu_rvalid, cpu_rdata, ext_rvalid, exp);
    end
    last_cpu_data = exp;
    $display("LW  addr=00000010 rdata=%h expected=%h", cpu_rdata, exp);
  endtask

  task automatic test_ext_preload();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive(0, 0, 0, 0, 1, 1, 0, 32'h20 + 32'(4 * i), 32'hC0DE0020 + 32'(4 * i));
      @(negedge clk);
      checks++;
      if (ext_gnt !== 1'b1 || cpu_gnt !== 1'b0 || ram_write_enable !== 1'b1) begin
        failures++;
        $display("FAIL ext_write%0d got ext_gnt=%b cpu_gnt=%b we=%b required 1 0 1", i, ext_gnt, cpu_gnt, ram_write_enable);
      end
      shadow[8 + i] = 32'hC0DE0020 + 32'(4 * i);
      $display("EXT SW addr=%h data=%h gnt=%b", ext_addr, ext_wdata, ext_gnt);
    end
  endtask

`ifndef RAM_ARB_RR_EN
  task automatic test_ext_burst();
    int beat = 0;
    logic exp_ext, prev_ext_rd = 1'b0;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      drive(1, 1, 32'h40, 32'h11110000 + 32'(cyc), (beat < 3), 0, 1, 32'h20 + 32'(4 * beat), 32'h0);
      @(negedge clk);
      exp_ext = (cyc >= 4 && cyc <= 6);
      checks++;
      if (ext_gnt !== exp_ext || cpu_gnt !== !exp_ext || cpu_stall !== exp_ext) begin
        failures++;
        $display("FAIL burst_gnt cyc%0d got cpu_gnt=%b ext_gnt=%b stall=%b required %b %b %b",
                 cyc, cpu_gnt, ext_gnt, cpu_stall, !exp_ext, exp_ext, exp_ext);
      end
      checks++;
      if (ext_rvalid !== prev_ext_rd) begin
        failures++;
        $display("FAIL burst_rvalid cyc%0d got ext_rvalid=%b required %b", cyc, ext_rvalid, prev_ext_rd);
      end
      if (prev_ext_rd) begin
        exp = ext_q.pop_front();
        checks++;
        if (ext_rdata !== exp) begin
          failures++;
          $display("FAIL burst_rdata cyc%0d got %h required %h", cyc, ext_rdata, exp);
        end
        last_ext_data = exp;
      end
      $display("BURST cyc=%0d cpu_gnt=%b ext_gnt=%b stall=%b ext_rvalid=%b ext_rdata=%h",
               cyc, cpu_gnt, ext_gnt, cpu_stall, ext_rvalid, ext_rdata);
      if (exp_ext) begin
        ext_q.push_back(shadow[8 + beat]);
        beat++;
      end else begin
        shadow[16] = 32'h11110000 + 32'(cyc);
      end
      prev_ext_rd = exp_ext;
    end
  endtask

  task automatic test_starvation();
    logic exp_ext, prev_ext_rd = 1'b0;
    logic [31:0] exp;
    for (int cyc = 0; cyc < 11; cyc++) begin
      @(posedge clk); #1;
      drive(1, 1, 32'h44, 32'h22220000 + 32'(cyc), 1, 0, 0, 32'h24, 32'h0);
      @(negedge clk);
      exp_ext = ((cyc % 5) == 4);
      checks++;
      if (ext_gnt !== exp_ext || cpu_gnt !== !exp_ext || cpu_stall !== exp_ext) begin
        failures++;
        $display("FAIL starve_gnt cyc%0d got cpu_gnt=%b ext_gnt=%b stall=%b required %b %b %b",
                 cyc, cpu_gnt, ext_gnt, cpu_stall, !exp_ext, exp_ext, exp_ext);
      end
      checks++;
      if (ext_rvalid !== prev_ext_rd || cpu_rvalid !== 1'b0) begin
        failures++;
        $display("FAIL starve_rvalid cyc%0d got ext_rvalid=%b cpu_rvalid=%b required %b 0",
                 cyc, ext_rvalid, cpu_rvalid, prev_ext_rd);
      end
      if (prev_ext_rd) begin
        exp = ext_q.pop_front();
        checks++;
        if (ext_rdata !== exp) begin
          failures++;
          $display("FAIL starve_rdata cyc%0d got %h required %h", cyc, ext_rdata, exp);
        end
        last_ext_data = exp;
      end
      $display("STARVE cyc=%0d cpu_gnt=%b ext_gnt=%b stall=%b", cyc, cpu_gnt, ext_gnt, cpu_stall);
      if (exp_ext) ext_q.push_back(shadow[9]);
      else         shadow[17] = 32'h22220000 + 32'(cyc);
      prev_ext_rd = exp_ext;
    end
  endtask
`else
  task automatic test_round_robin();
    logic prev_cpu = 1'b0;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      drive(1, 1, 32'h44, 32'h33330000 + 32'(cyc), 1, 1, 0, 32'h48, 32'h44440000 + 32'(cyc));
      @(negedge clk);
      checks++;
      if (ext_gnt !== !cpu_gnt || (cyc > 0 && cpu_gnt === prev_cpu)) begin
        failures++;
        $display("FAIL rr_alternate cyc%0d got cpu_gnt=%b ext_gnt=%b prev_cpu=%b required alternating single grant",
                 cyc, cpu_gnt, ext_gnt, prev_cpu);
      end
      $display("RR cyc=%0d cpu_gnt=%b ext_gnt=%b", cyc, cpu_gnt, ext_gnt);
      prev_cpu = cpu_gnt;
      @(posedge clk); #1;
    end
    last_cpu_data = 32'h0;
    last_ext_data = 32'h0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] exp;
    @(posedge clk); #1;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_cpu_gnt got gnt=%b rvalid=%b/%b required 1 0/0", cpu_gnt, cpu_rvalid, ext_rvalid);
    end
    cpu_q.push_back(shadow[4]);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 0, 0, 32'h28, 0);
    @(negedge clk);
    exp = cpu_q.pop_front();
    checks++;
    if (ext_gnt !== 1'b1 || cpu_rvalid !== 1'b1 || cpu_rdata !== exp || ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_n1 got ext_gnt=%b cpu_rvalid=%b cpu_rdata=%h ext_rvalid=%b required 1 1 %h 0",
               ext_gnt, cpu_rvalid, cpu_rdata, ext_rvalid, exp);
    end
    checks++;
    if (ext_rdata !== last_ext_data) begin
      failures++;
      $display("FAIL b2b_ext_hold got %h required %h", ext_rdata, last_ext_data);
    end
    last_cpu_data = exp;
    ext_q.push_back(shadow[10]);
    $display("B2B n+1 cpu_rvalid=%b cpu_rdata=%h ext_gnt=%b", cpu_rvalid, cpu_rdata, ext_gnt);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    exp = ext_q.pop_front();
    checks++;
    if (ext_rvalid !== 1'b1 || ext_rdata !== exp || cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_n2 got ext_rvalid=%b ext_rdata=%h cpu_rvalid=%b required 1 %h 0",
               ext_rvalid, ext_rdata, cpu_rvalid, exp);
    end
    checks++;
    if (cpu_rdata !== last_cpu_data) begin
      failures++;
      $display("FAIL b2b_cpu_hold got %h required %h", cpu_rdata, last_cpu_data);
    end
    last_ext_data = exp;
    $display("B2B n+2 ext_rvalid=%b ext_rdata=%h", ext_rvalid, ext_rdata);
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0 || cpu_rdata !== last_cpu_data || ext_rdata !== last_ext_data) begin
      failures++;
      $display("FAIL b2b_idle got rvalid=%b/%b rdata=%h/%h required 0/0 %h/%h",
               cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata, last_cpu_data, last_ext_data);
    end
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    drive(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (cpu_gnt !== 1'b1 || ram_read_enable !== 1'b1) begin
      failures++;
      $display("FAIL midrd_gnt got gnt=%b re=%b required 1 1", cpu_gnt, ram_read_enable);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if ({cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, ram_read_enable, ram_write_enable} !== 6'b0 ||
        cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midrd_reset got gnt=%b/%b rvalid=%b/%b rdata=%h/%h required all 0",
               cpu_gnt, ext_gnt, cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || ext_rvalid !== 1'b0 || cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin
      failures++;
      $display("FAIL midrd_after got rvalid=%b/%b rdata=%h/%h required 0/0 0/0",
               cpu_rvalid, ext_rvalid, cpu_rdata, ext_rdata);
    end
    cpu_q.delete();
    ext_q.delete();
    $display("RESET mid-read cpu_rvalid=%b cpu_rdata=%h", cpu_rvalid, cpu_rdata);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      shadow[i] = 32'h0;
    end
    test_reset();
    test_store_load();
    test_ext_preload();
`ifndef RAM_ARB_RR_EN
    test_ext_burst();
    test_starvation();
`else
    test_round_robin();
`endif
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
